// File: rtl/am_search_ctrl_pkg.sv
// Shared types and constants for the associative-memory search controller.
//   am_ctrl_state_e : sequencer states (IDLE, START, STREAM, WAIT_AM)
//   AmFifoDepth     : depth of the class-HV staging FIFO
//   AmFifoCntWidth  : width of the FIFO occupancy count (0..AmFifoDepth)
package am_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      STREAM,
      WAIT_AM
   } am_ctrl_state_e;

   localparam int AmFifoDepth    = 2;
   localparam int AmFifoCntWidth = $clog2(AmFifoDepth + 1);

endpackage

// File: rtl/am_search_ctrl_if.sv
// Link between the search controller and the assoc_mem datapath.
//   am_start        : 1-cycle start pulse to the AM
//   am_busy         : AM busy
//   am_max_arg_idx  : AM best-match class index
//   class_hv        : class hypervector streamed to the AM
//   class_hv_valid  : class_hv holds data
//   class_hv_ready  : AM accepts class_hv this cycle
// Modports: master = controller side, slave = AM side.
interface am_search_ctrl_if #(
   parameter int HVDimension = 512,
   parameter int DataWidth   = 8
);

   logic                   am_start;
   logic                   am_busy;
   logic [DataWidth-1:0]   am_max_arg_idx;
   logic [HVDimension-1:0] class_hv;
   logic                   class_hv_valid;
   logic                   class_hv_ready;

   modport master (
      output am_start, class_hv, class_hv_valid,
      input  am_busy, am_max_arg_idx, class_hv_ready
   );

   modport slave (
      input  am_start, class_hv, class_hv_valid,
      output am_busy, am_max_arg_idx, class_hv_ready
   );

endinterface

// File: rtl/am_search_ctrl_class_fifo.sv
// am_class_fifo: AmFifoDepth-entry staging FIFO for class hypervectors read
// from the class SRAM on their way to the AM.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush        : synchronous flush (empties the FIFO)
//   push, push_data : write one entry
//   pop          : remove the head entry
//   head         : current head entry (meaningful only when count != 0)
//   count        : current occupancy
module am_class_fifo
   import am_ctrl_pkg::*;
#(
   parameter int HVDimension = 512
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush,
   input  logic                      push,
   input  logic [HVDimension-1:0]    push_data,
   input  logic                      pop,
   output logic [HVDimension-1:0]    head,
   output logic [AmFifoCntWidth-1:0] count
);

   localparam int PtrWidth = $clog2(AmFifoDepth);

   logic [HVDimension-1:0] mem [AmFifoDepth];
   logic [PtrWidth-1:0]    wr_ptr;
   logic [PtrWidth-1:0]    rd_ptr;

   // NOTE: the storage array has no reset; only pointers and count do. An
   // empty FIFO never exposes stale data because the consumer gates on count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
         if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
         count <= count + AmFifoCntWidth'(push) - AmFifoCntWidth'(pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/am_search_ctrl.sv
// am_search_ctrl: sequences one associative-memory search. On an accepted
// start it pulses the AM start, reads class HVs 0..N-1 from the class SRAM
// (1-cycle read latency) through a 2-entry FIFO, streams them to the AM over
// valid/ready, then captures the winning class index.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   search_start_i        : search request (level, sampled in IDLE)
//   search_busy_o         : high while not IDLE
//   search_done_o         : 1-cycle pulse when the result is captured
//   result_valid_o/idx_o  : captured winner, held until next accepted start
//   cfg_err_o             : 1-cycle pulse, start rejected (bad num_class)
//   csr_num_class_i       : number of classes to compare (1..ClassMemDepth)
//   cmem_req_o/addr_o     : class SRAM read request/address
//   cmem_rdata_i          : SRAM read data, valid the cycle after the request
//   am_if                 : AM start/busy/index and class-HV stream (master)
//   perf_cycles_o         : search latency in cycles
// Optional feature: define AM_PERF_CNT_EN to build the 16-bit saturating
// busy-cycle counter; otherwise perf_cycles_o is tied to zero.
module am_search_ctrl
   import am_ctrl_pkg::*;
#(
   parameter int HVDimension   = 512,
   parameter int DataWidth     = 8,
   parameter int ClassMemDepth = 32,
   parameter int AddrWidth     = $clog2(ClassMemDepth)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   search_start_i,
   output logic                   search_busy_o,
   output logic                   search_done_o,
   output logic                   result_valid_o,
   output logic [DataWidth-1:0]   result_idx_o,
   output logic                   cfg_err_o,
   input  logic [DataWidth-1:0]   csr_num_class_i,
   output logic                   cmem_req_o,
   output logic [AddrWidth-1:0]   cmem_addr_o,
   input  logic [HVDimension-1:0] cmem_rdata_i,
   am_search_ctrl_if.master       am_if,
   output logic [15:0]            perf_cycles_o
);

   am_ctrl_state_e              state;
   logic [DataWidth-1:0]        num_class;   // latched N, immune to later CSR writes
   logic [DataWidth-1:0]        rd_addr;
   logic [DataWidth-1:0]        sent;
   logic                        inflight;    // a read issued last cycle lands now
   logic [AmFifoCntWidth-1:0]   fifo_cnt;
   logic [AmFifoCntWidth:0]     credit_used;
   logic [HVDimension-1:0]      fifo_head;
   logic                        num_ok;
   logic                        accept;
   logic                        pop;

   assign num_ok = (csr_num_class_i != '0) &&
                   (csr_num_class_i <= DataWidth'(ClassMemDepth));
   assign accept = (state == IDLE) && search_start_i && num_ok;

   assign am_if.class_hv_valid = (state == STREAM) && (fifo_cnt != '0);
   assign am_if.class_hv       = am_if.class_hv_valid ? fifo_head : '0;
   assign pop                  = am_if.class_hv_valid && am_if.class_hv_ready;

   // Entries that will occupy the FIFO after this edge if no new read is
   // issued: what stays after the pop plus the read already in flight.
   // Issuing only while this is below the depth keeps the FIFO from
   // overflowing while still allowing one read per cycle at full throughput.
   assign credit_used = (AmFifoCntWidth + 1)'(fifo_cnt) - (AmFifoCntWidth + 1)'(pop)
                      + (AmFifoCntWidth + 1)'(inflight);
   assign cmem_req_o  = (state == STREAM) && (rd_addr < num_class) &&
                        (credit_used < (AmFifoCntWidth + 1)'(AmFifoDepth));
   assign cmem_addr_o = rd_addr[AddrWidth-1:0];

   am_class_fifo #(
      .HVDimension (HVDimension)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush     (state == START),
      .push      (inflight),
      .push_data (cmem_rdata_i),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_cnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         num_class      <= '0;
         rd_addr        <= '0;
         sent           <= '0;
         inflight       <= 1'b0;
         search_busy_o  <= 1'b0;
         search_done_o  <= 1'b0;
         result_valid_o <= 1'b0;
         result_idx_o   <= '0;
         cfg_err_o      <= 1'b0;
         am_if.am_start <= 1'b0;
      end else begin
         // Pulse outputs default low; the states below raise them for one cycle.
         search_done_o  <= 1'b0;
         cfg_err_o      <= 1'b0;
         am_if.am_start <= 1'b0;
         inflight       <= cmem_req_o;
         if (cmem_req_o) rd_addr <= rd_addr + DataWidth'(1);
         if (pop)        sent    <= sent + DataWidth'(1);

         unique case (state)
            IDLE: begin
               if (accept) begin
                  num_class      <= csr_num_class_i;
                  result_valid_o <= 1'b0;
                  search_busy_o  <= 1'b1;
                  am_if.am_start <= 1'b1;
                  state          <= START;
               end else if (search_start_i) begin
                  cfg_err_o <= 1'b1;
               end
            end
            START: begin
               rd_addr <= '0;
               sent    <= '0;
               state   <= STREAM;
            end
            STREAM: begin
               if (pop && (sent + DataWidth'(1) == num_class)) begin
                  state <= WAIT_AM;
               end
            end
            WAIT_AM: begin
               if (!am_if.am_busy) begin
                  result_idx_o   <= am_if.am_max_arg_idx;
                  result_valid_o <= 1'b1;
                  search_done_o  <= 1'b1;
                  search_busy_o  <= 1'b0;
                  state          <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef AM_PERF_CNT_EN
   logic [15:0] perf_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || accept) begin
         perf_cnt <= '0;
      end else if (search_busy_o && (perf_cnt != 16'hFFFF)) begin
         perf_cnt <= perf_cnt + 16'd1;
      end
   end

   assign perf_cycles_o = perf_cnt;
`else
   assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_am_search_ctrl.sv
// Self-checking bench for am_search_ctrl. A class-memory model answers reads
// one cycle late, an AM model holds busy while HVs are outstanding plus a
// configurable tail, and a per-search scoreboard checks address order, data
// order, FIFO bound, and done/result/busy timing derived from the search rules.
module tb_am_search_ctrl;

   localparam int HVD   = 512;
   localparam int DW    = 8;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic           clk = 1'b0;
   logic           rst_i;
   logic           search_start_i;
   logic           search_busy_o, search_done_o, result_valid_o, cfg_err_o;
   logic [DW-1:0]  result_idx_o;
   logic [DW-1:0]  csr_num_class_i;
   logic           cmem_req_o;
   logic [AW-1:0]  cmem_addr_o;
   logic [HVD-1:0] cmem_rdata_i;
   logic [15:0]    perf_cycles_o;

   am_search_ctrl_if #(.HVDimension(HVD), .DataWidth(DW)) am_if ();

   am_search_ctrl #(
      .HVDimension(HVD), .DataWidth(DW), .ClassMemDepth(DEPTH)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .search_start_i  (search_start_i),
      .search_busy_o   (search_busy_o),
      .search_done_o   (search_done_o),
      .result_valid_o  (result_valid_o),
      .result_idx_o    (result_idx_o),
      .cfg_err_o       (cfg_err_o),
      .csr_num_class_i (csr_num_class_i),
      .cmem_req_o      (cmem_req_o),
      .cmem_addr_o     (cmem_addr_o),
      .cmem_rdata_i    (cmem_rdata_i),
      .am_if           (am_if),
      .perf_cycles_o   (perf_cycles_o)
   );

   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int n_cmp = 0;
   int n_fail = 0;

   logic [HVD-1:0] cmem_model [DEPTH];

   // drive controls, applied inside run_cycle at the falling edge
   logic          rst_drv, start_drv;
   logic [DW-1:0] csr_drv;
   logic [DW-1:0] am_idx_val;
   int            ready_mode;   // 0: always 1, 1: 1010.., 2: random
   int            busy_tail;

   // per-search scoreboard
   int cyc, cur_n;
   logic pend_req;
   logic [AW-1:0] pend_addr;
   int n_req, n_pop, next_addr, order_err, max_occ, last_pop, tail_left;
   int am_start_cnt, am_start_cyc, done_cnt, done_cyc, err_cnt, err_cyc;
   int busy_cnt, busy_first, first_req, first_valid;
   bit am_active;
   int res_at_done, rv_at_done, perf_at_done;

   typedef struct {
      int       n;
      int       mode;
      int       tail;
      logic [7:0] idx;
      bit       exp_err;
      int       exp_done;   // -1: derived from the observed last pop
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic fill_cmem();
      for (int i = 0; i < DEPTH; i++)
         for (int w = 0; w < HVD / 32; w++)
            cmem_model[i][w*32 +: 32] = $urandom;
   endtask

   task automatic begin_search(input int n);
      cur_n = n; cyc = 0;
      n_req = 0; n_pop = 0; next_addr = 0; order_err = 0; max_occ = 0;
      last_pop = -1; tail_left = 0; am_active = 1'b0;
      am_start_cnt = 0; am_start_cyc = -1; done_cnt = 0; done_cyc = -1;
      err_cnt = 0; err_cyc = -1; busy_cnt = 0; busy_first = -1;
      first_req = -1; first_valid = -1;
      res_at_done = -1; rv_at_done = -1; perf_at_done = -1;
   endtask

   // One clock cycle: drive at the falling edge, sample 1 ns later.
   task automatic run_cycle();
      logic [HVD-1:0] junk;
      @(negedge clk);
      rst_i           = rst_drv;
      search_start_i  = start_drv;
      csr_num_class_i = csr_drv;
      for (int w = 0; w < HVD / 32; w++) junk[w*32 +: 32] = $urandom;
      cmem_rdata_i = pend_req ? cmem_model[pend_addr] : junk;
      case (ready_mode)
         0:       am_if.class_hv_ready = 1'b1;
         1:       am_if.class_hv_ready = (cyc % 2 == 0);
         default: am_if.class_hv_ready = 1'($urandom_range(0, 1));
      endcase
      if (am_active && n_pop >= cur_n && tail_left > 0) begin
         am_if.am_busy = 1'b1;
         tail_left--;
      end else begin
         am_if.am_busy = am_active && (n_pop < cur_n);
      end
      am_if.am_max_arg_idx = am_idx_val;
      #1;
      if (cmem_req_o) begin
         if (int'(cmem_addr_o) != next_addr) order_err++;
         if (first_req < 0) first_req = cyc;
         n_req++; next_addr++;
         pend_req = 1'b1; pend_addr = cmem_addr_o;
      end else begin
         pend_req = 1'b0;
      end
      if (am_if.class_hv_valid && first_valid < 0) first_valid = cyc;
      if (am_if.class_hv_valid && am_if.class_hv_ready) begin
         if (n_pop >= cur_n || am_if.class_hv !== cmem_model[n_pop]) order_err++;
         n_pop++; last_pop = cyc;
         if (n_pop == cur_n) tail_left = busy_tail;
      end
      if (n_req - n_pop > max_occ) max_occ = n_req - n_pop;
      if (am_if.am_start) begin am_start_cnt++; am_start_cyc = cyc; am_active = 1'b1; end
      if (search_done_o) begin
         done_cnt++; done_cyc = cyc; am_active = 1'b0;
         res_at_done = int'(result_idx_o); rv_at_done = int'(result_valid_o);
         perf_at_done = int'(perf_cycles_o);
      end
      if (cfg_err_o) begin err_cnt++; err_cyc = cyc; end
      if (search_busy_o) begin busy_cnt++; if (busy_first < 0) busy_first = cyc; end
      cyc++;
   endtask

   task automatic run_until_done(input int limit);
      while (done_cnt == 0 && cyc < limit) run_cycle();
   endtask

   function automatic int exp_perf(input int done_at);
`ifdef AM_PERF_CNT_EN
      return done_at - 1;
`else
      return 0 * done_at;
`endif
   endfunction

   // Launch and fully check one search described by a vector.
   task automatic do_vector(input vec_t v, input string tag);
      ready_mode = v.mode; busy_tail = v.tail; am_idx_val = v.idx;
      begin_search(v.n);
      csr_drv = DW'(v.n); start_drv = 1'b1;
      run_cycle();
      start_drv = 1'b0;
      if (v.exp_err) begin
         repeat (6) run_cycle();
         check({tag, " cfg_err count"}, err_cnt, 1);
         check({tag, " cfg_err cycle"}, err_cyc, 1);
         check({tag, " am_start count"}, am_start_cnt, 0);
         check({tag, " busy cycles"}, busy_cnt, 0);
         check({tag, " reads"}, n_req, 0);
      end else begin
         run_until_done(600);
         check({tag, " done count"}, done_cnt, 1);
         check({tag, " cfg_err count"}, err_cnt, 0);
         check({tag, " am_start count"}, am_start_cnt, 1);
         check({tag, " am_start cycle"}, am_start_cyc, 1);
         check({tag, " reads"}, n_req, v.n);
         check({tag, " pops"}, n_pop, v.n);
         check({tag, " order errors"}, order_err, 0);
         check({tag, " fifo bound"}, int'(max_occ <= 2), 1);
         check({tag, " done vs last pop"}, done_cyc, last_pop + 2 + v.tail);
         if (v.exp_done >= 0) begin
            check({tag, " done cycle"}, done_cyc, v.exp_done);
            check({tag, " first req cycle"}, first_req, 2);
            check({tag, " first valid cycle"}, first_valid, 4);
         end
         check({tag, " result idx"}, res_at_done, int'(v.idx));
         check({tag, " result valid"}, rv_at_done, 1);
         check({tag, " busy first"}, busy_first, 1);
         check({tag, " busy cycles"}, busy_cnt, done_cyc - 1);
         check({tag, " perf"}, perf_at_done, exp_perf(done_cyc));
         repeat (2) run_cycle();
         check({tag, " result held"}, int'(result_valid_o), 1);
         check({tag, " extra done"}, done_cnt, 1);
      end
   endtask

   vec_t vecs [9];
   vec_t rv;

   initial begin
      rst_drv = 1'b1; start_drv = 1'b0; csr_drv = '0; am_idx_val = '0;
      ready_mode = 0; busy_tail = 0; pend_req = 1'b0; pend_addr = '0;
      am_if.am_busy = 1'b0; am_if.am_max_arg_idx = '0; am_if.class_hv_ready = 1'b0;
      fill_cmem();
      begin_search(0);

      // ---- reset state ----
      repeat (3) run_cycle();
      rst_drv = 1'b0;
      run_cycle();
      check("reset busy", int'(search_busy_o), 0);
      check("reset done/valid/err", int'({search_done_o, result_valid_o, cfg_err_o}), 0);
      check("reset result idx", int'(result_idx_o), 0);
      check("reset am_start/req/hv_valid",
            int'({am_if.am_start, cmem_req_o, am_if.class_hv_valid}), 0);
      check("reset perf", int'(perf_cycles_o), 0);

      // ---- table-driven vectors ----
      vecs[0] = '{4,  0, 0, 8'd2,  1'b0, 9};
      vecs[1] = '{1,  0, 0, 8'd5,  1'b0, 6};
      vecs[2] = '{32, 0, 0, 8'd31, 1'b0, 37};
      vecs[3] = '{4,  1, 0, 8'd3,  1'b0, -1};
      vecs[4] = '{0,  0, 0, 8'd0,  1'b1, -1};
      vecs[5] = '{33, 0, 0, 8'd0,  1'b1, -1};
      vecs[6] = '{255, 0, 0, 8'd0, 1'b1, -1};
      vecs[7] = '{6,  0, 3, 8'd1,  1'b0, -1};
      vecs[8] = '{7,  2, 1, 8'd4,  1'b0, -1};
      for (int i = 0; i < 9; i++) begin
         do_vector(vecs[i], $sformatf("vec%0d", i));
         repeat (2) run_cycle();
      end

      // ---- N=1, CSR rewritten after the start is accepted ----
      ready_mode = 0; busy_tail = 0; am_idx_val = 8'd9;
      begin_search(1);
      csr_drv = 8'd1; start_drv = 1'b1;
      run_cycle();
      start_drv = 1'b0; csr_drv = 8'd20;
      run_until_done(100);
      check("csr change reads", n_req, 1);
      check("csr change order", order_err, 0);
      check("csr change done cycle", done_cyc, 6);
      check("csr change result", res_at_done, 9);
      repeat (2) run_cycle();

      // ---- start held high: one search per idle accept ----
      ready_mode = 0; am_idx_val = 8'd7;
      begin_search(3);
      csr_drv = 8'd3; start_drv = 1'b1;
      run_until_done(100);
      check("held start done cycle", done_cyc, 8);
      check("held start single am_start", am_start_cnt, 1);
      check("held start result valid at done", rv_at_done, 1);
      run_cycle();
      check("held start restart drops result_valid", int'(result_valid_o), 0);
      check("held start restart am_start", int'(am_if.am_start), 1);
      start_drv = 1'b0;
      begin_search(3);
      cyc = 2; am_active = 1'b1;
      run_until_done(100);
      check("held start second done cycle", done_cyc, 8);
      check("held start second reads", n_req, 3);
      check("held start no extra am_start", am_start_cnt, 0);
      repeat (2) run_cycle();

      // ---- reset in the middle of STREAM ----
      ready_mode = 0; am_idx_val = 8'd1;
      begin_search(8);
      csr_drv = 8'd8; start_drv = 1'b1;
      run_cycle();
      start_drv = 1'b0;
      while (n_pop < 3 && cyc < 50) run_cycle();
      check("mid reset pops before reset", n_pop, 3);
      rst_drv = 1'b1;
      run_cycle();
      rst_drv = 1'b0;
      run_cycle();
      check("mid reset busy", int'(search_busy_o), 0);
      check("mid reset hv_valid", int'(am_if.class_hv_valid), 0);
      check("mid reset req", int'(cmem_req_o), 0);
      repeat (12) run_cycle();
      check("mid reset no done", done_cnt, 0);

      // ---- randomized searches against the scoreboard ----
      for (int k = 0; k < 25; k++) begin
         fill_cmem();
         rv.n        = int'($urandom_range(1, DEPTH));
         rv.mode     = int'($urandom_range(0, 2));
         rv.tail     = int'($urandom_range(0, 4));
         rv.idx      = 8'($urandom_range(0, 255));
         rv.exp_err  = 1'b0;
         rv.exp_done = (rv.mode == 0 && rv.tail == 0) ? rv.n + 5 : -1;
         do_vector(rv, $sformatf("rand%0d", k));
         repeat (int'($urandom_range(0, 3))) run_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
